// File: rtl/exu_wb_seq_pkg.sv
// rtl/exu_wb_seq_pkg.sv - shared codes, state encoding and helpers for the EXU writeback stage
package exu_wb_seq_pkg;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_LINK = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } state_e;

    // Width of the byte-offset field inside one datapath word.
    function automatic int ofs_w(input int isa_width);
        return $clog2(isa_width / 8);
    endfunction

    // Keyed select over the four load sizes; callers pass values zero-padded
    // to 64 bits and truncate the result back to their own width.
    function automatic logic [63:0] mux_key_with_default(
        input logic [1:0]  key,
        input logic [63:0] val_b,
        input logic [63:0] val_h,
        input logic [63:0] val_w,
        input logic [63:0] val_d,
        input logic [63:0] dflt
    );
        logic [63:0] res;
        case (key)
            LD_B:    res = val_b;
            LD_H:    res = val_h;
            LD_W:    res = val_w;
            LD_D:    res = val_d;
            default: res = dflt;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/exu_wb_ldext.sv
// rtl/exu_wb_ldext.sv - load lane selection and sign/zero extension
// Ports:
//   i_rdata    naturally aligned memory word containing the load
//   i_size     load size code (B/H/W/D)
//   i_unsigned 1 = zero-extend, 0 = sign-extend
//   i_addr_lo  byte offset of the load inside the word
//   o_data     extended load value
module exu_wb_ldext
    import exu_wb_seq_pkg::*;
#(
    parameter int  ISA_WIDTH = 32,
    localparam int OFS_W     = ofs_w(ISA_WIDTH)
) (
    input  logic [ISA_WIDTH-1:0] i_rdata,
    input  logic [1:0]           i_size,
    input  logic                 i_unsigned,
    input  logic [OFS_W-1:0]     i_addr_lo,
    output logic [ISA_WIDTH-1:0] o_data
);

    logic [7:0]           w_lane_b;
    logic [15:0]          w_lane_h;
    logic [ISA_WIDTH-1:0] w_ext_b;
    logic [ISA_WIDTH-1:0] w_ext_h;
    logic [ISA_WIDTH-1:0] w_ext_w;
    logic [ISA_WIDTH-1:0] w_ext_d;

    // Misaligned offsets align down: the halfword drops addr bit 0.
    assign w_lane_b = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_lane_h = i_rdata[{i_addr_lo[OFS_W-1:1], 4'b0000} +: 16];

    assign w_ext_b = {{(ISA_WIDTH-8){~i_unsigned & w_lane_b[7]}}, w_lane_b};
    assign w_ext_h = {{(ISA_WIDTH-16){~i_unsigned & w_lane_h[15]}}, w_lane_h};

    if (ISA_WIDTH == 64) begin : g_w64
        logic [31:0] w_lane_w;
        assign w_lane_w = i_rdata[{i_addr_lo[2], 5'b00000} +: 32];
        assign w_ext_w  = {{32{~i_unsigned & w_lane_w[31]}}, w_lane_w};
        assign w_ext_d  = i_rdata;
    end else begin : g_w32
        // A word fills the datapath, so signedness is moot and D folds onto W.
        assign w_ext_w = i_rdata;
        assign w_ext_d = i_rdata;
    end

    assign o_data = ISA_WIDTH'(mux_key_with_default(i_size,
                                                    64'(w_ext_b),
                                                    64'(w_ext_h),
                                                    64'(w_ext_w),
                                                    64'(w_ext_d),
                                                    64'd0));

endmodule

// File: rtl/exu_wb_seq.sv
// rtl/exu_wb_seq.sv - sequential EXU writeback stage with load wait and timeout
// Ports:
//   clk, rst                    clock; asynchronous active-low reset
//   in_valid/in_ready           retiring-instruction handshake from execute
//   in_rd, in_wb_sel            destination register and writeback source
//   in_ld_size, in_ld_unsigned  load size and extension mode
//   in_addr_lo                  low bits of the load address
//   in_alu_result, in_pc        ALU result and instruction PC (LINK writes pc+4)
//   mem_rvalid/mem_rready       load response handshake, mem_rdata payload
//   gpr_w_en/addr/data          registered GPR write port
//   commit_valid, err_timeout   retire pulse and load-abort pulse
module exu_wb_seq
    import exu_wb_seq_pkg::*;
#(
    parameter int  ISA_WIDTH  = 32,
    parameter int  REG_ADDR_W = 5,
    parameter int  TIMEOUT    = 255,
    parameter int  CNT_W      = 8,
    localparam int OFS_W      = ofs_w(ISA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [1:0]            in_wb_sel,
    input  logic [1:0]            in_ld_size,
    input  logic                  in_ld_unsigned,
    input  logic [OFS_W-1:0]      in_addr_lo,
    input  logic [ISA_WIDTH-1:0]  in_alu_result,
    input  logic [ISA_WIDTH-1:0]  in_pc,
    input  logic                  mem_rvalid,
    input  logic [ISA_WIDTH-1:0]  mem_rdata,
    output logic                  mem_rready,
    output logic                  gpr_w_en,
    output logic [REG_ADDR_W-1:0] gpr_w_addr,
    output logic [ISA_WIDTH-1:0]  gpr_w_data,
    output logic                  commit_valid,
    output logic                  err_timeout
);

    localparam logic [CNT_W-1:0] LP_TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_e                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [1:0]            r_size;
    logic                  r_uns;
    logic [OFS_W-1:0]      r_addr_lo;
    logic                  r_w_en;
    logic [REG_ADDR_W-1:0] r_w_addr;
    logic [ISA_WIDTH-1:0]  r_w_data;
    logic                  r_commit;
    logic                  r_err;

    state_e                w_state_nx;
    logic [CNT_W-1:0]      w_cnt_nx;
    logic [REG_ADDR_W-1:0] w_rd_nx;
    logic [1:0]            w_size_nx;
    logic                  w_uns_nx;
    logic [OFS_W-1:0]      w_addr_lo_nx;
    logic                  w_w_en_nx;
    logic [REG_ADDR_W-1:0] w_w_addr_nx;
    logic [ISA_WIDTH-1:0]  w_w_data_nx;
    logic                  w_commit_nx;
    logic                  w_err_nx;
    logic [ISA_WIDTH-1:0]  w_ld_data;

    exu_wb_ldext #(
        .ISA_WIDTH (ISA_WIDTH)
    ) u_ldext (
        .i_rdata    (mem_rdata),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .i_addr_lo  (r_addr_lo),
        .o_data     (w_ld_data)
    );

    assign in_ready     = (r_state == S_IDLE);
    assign mem_rready   = (r_state == S_WAIT_MEM);
    assign gpr_w_en     = r_w_en;
    assign gpr_w_addr   = r_w_addr;
    assign gpr_w_data   = r_w_data;
    assign commit_valid = r_commit;
    assign err_timeout  = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rd      <= '0;
            r_size    <= '0;
            r_uns     <= 1'b0;
            r_addr_lo <= '0;
            r_w_en    <= 1'b0;
            r_w_addr  <= '0;
            r_w_data  <= '0;
            r_commit  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_rd      <= w_rd_nx;
            r_size    <= w_size_nx;
            r_uns     <= w_uns_nx;
            r_addr_lo <= w_addr_lo_nx;
            r_w_en    <= w_w_en_nx;
            r_w_addr  <= w_w_addr_nx;
            r_w_data  <= w_w_data_nx;
            r_commit  <= w_commit_nx;
            r_err     <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_rd_nx      = r_rd;
        w_size_nx    = r_size;
        w_uns_nx     = r_uns;
        w_addr_lo_nx = r_addr_lo;
        w_w_en_nx    = 1'b0;
        w_w_addr_nx  = r_w_addr;
        w_w_data_nx  = r_w_data;
        w_commit_nx  = 1'b0;
        w_err_nx     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_wb_sel == WB_MEM) begin
                        w_rd_nx      = in_rd;
                        w_size_nx    = in_ld_size;
                        w_uns_nx     = in_ld_unsigned;
                        w_addr_lo_nx = in_addr_lo;
                        w_cnt_nx     = '0;
                        w_state_nx   = S_WAIT_MEM;
                    end else begin
                        // NONE still retires; x0 is never written.
                        w_w_en_nx   = (in_wb_sel != WB_NONE) && (in_rd != '0);
                        w_w_addr_nx = in_rd;
                        w_w_data_nx = (in_wb_sel == WB_ALU) ? in_alu_result
                                                            : in_pc + ISA_WIDTH'(4);
                        w_commit_nx = 1'b1;
                    end
                end
            end
            S_WAIT_MEM: begin
                // A response in the expiry cycle takes priority over the abort.
                if (mem_rvalid) begin
                    w_w_en_nx   = (r_rd != '0);
                    w_w_addr_nx = r_rd;
                    w_w_data_nx = w_ld_data;
                    w_commit_nx = 1'b1;
                    w_state_nx  = S_IDLE;
                end else if ((TIMEOUT != 0) && (r_cnt == LP_TMO_LAST)) begin
                    w_err_nx    = 1'b1;
                    w_commit_nx = 1'b1;
                    w_state_nx  = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_exu_wb_seq.sv
// tb/tb_exu_wb_seq.sv - self-checking bench for exu_wb_seq at 32 and 64 bit widths
module tb_exu_wb_seq;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        t_valid;
    logic [1:0]  t_sel;
    logic [4:0]  t_rd;
    logic [1:0]  t_size;
    logic        t_uns;
    logic [2:0]  t_addr;
    logic [63:0] t_alu;
    logic [63:0] t_pc;
    logic        t_rvalid;
    logic [63:0] t_rdata;

    logic        o32_ready, o32_rready, o32_en, o32_commit, o32_err;
    logic [4:0]  o32_addr;
    logic [31:0] o32_data;
    logic        o64_ready, o64_rready, o64_en, o64_commit, o64_err;
    logic [4:0]  o64_addr;
    logic [63:0] o64_data;

    exu_wb_seq #(.ISA_WIDTH(32), .REG_ADDR_W(5), .TIMEOUT(TMO), .CNT_W(8)) u_dut32 (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (t_valid),
        .in_ready       (o32_ready),
        .in_rd          (t_rd),
        .in_wb_sel      (t_sel),
        .in_ld_size     (t_size),
        .in_ld_unsigned (t_uns),
        .in_addr_lo     (t_addr[1:0]),
        .in_alu_result  (t_alu[31:0]),
        .in_pc          (t_pc[31:0]),
        .mem_rvalid     (t_rvalid),
        .mem_rdata      (t_rdata[31:0]),
        .mem_rready     (o32_rready),
        .gpr_w_en       (o32_en),
        .gpr_w_addr     (o32_addr),
        .gpr_w_data     (o32_data),
        .commit_valid   (o32_commit),
        .err_timeout    (o32_err)
    );

    exu_wb_seq #(.ISA_WIDTH(64), .REG_ADDR_W(5), .TIMEOUT(TMO), .CNT_W(8)) u_dut64 (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (t_valid),
        .in_ready       (o64_ready),
        .in_rd          (t_rd),
        .in_wb_sel      (t_sel),
        .in_ld_size     (t_size),
        .in_ld_unsigned (t_uns),
        .in_addr_lo     (t_addr),
        .in_alu_result  (t_alu),
        .in_pc          (t_pc),
        .mem_rvalid     (t_rvalid),
        .mem_rdata      (t_rdata),
        .mem_rready     (o64_rready),
        .gpr_w_en       (o64_en),
        .gpr_w_addr     (o64_addr),
        .gpr_w_data     (o64_data),
        .commit_valid   (o64_commit),
        .err_timeout    (o64_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: one outstanding load, counted in cycles spent waiting.
    logic        m_busy = 1'b0;
    int          m_waited = 0;
    logic [4:0]  m_rd = '0;
    logic [1:0]  m_size = '0;
    logic        m_uns = 1'b0;
    logic [2:0]  m_addr = '0;
    logic        e_en = 1'b0, e_commit = 1'b0, e_err = 1'b0;
    logic [4:0]  e_addr = '0;
    logic [63:0] e_data [2] = '{64'd0, 64'd0};

    typedef struct {
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  addr;
        logic [63:0] alu;
        logic [63:0] pc;
        logic [63:0] rdata;
        int          wait_n;
        logic        exp_en;
        logic [63:0] exp32;
        logic [63:0] exp64;
    } vec_t;

    vec_t vt [15];

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] m_ldext(input int w, input logic [63:0] rd,
                                            input logic [1:0] size, input logic uns,
                                            input logic [2:0] addr);
        int bytes, a, off;
        logic [63:0] lmask, lane;
        bytes = 1 << size;
        if (w == 32 && bytes == 8) bytes = 4;
        a     = int'(addr) % (w / 8);
        off   = a - (a % bytes);
        lmask = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (bytes * 8)) - 64'd1);
        lane  = ((rd & wmask(w)) >> (off * 8)) & lmask;
        if (!uns && (bytes * 8 < w) && lane[bytes*8-1]) lane = lane | ~lmask;
        return lane & wmask(w);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_ready();
        chk("in_ready32",   64'(o32_ready),  64'(!m_busy));
        chk("in_ready64",   64'(o64_ready),  64'(!m_busy));
        chk("mem_rready32", 64'(o32_rready), 64'(m_busy));
        chk("mem_rready64", 64'(o64_rready), 64'(m_busy));
    endtask

    task automatic check_outs();
        chk("gpr_w_en32",   64'(o32_en),     64'(e_en));
        chk("gpr_w_en64",   64'(o64_en),     64'(e_en));
        chk("commit32",     64'(o32_commit), 64'(e_commit));
        chk("commit64",     64'(o64_commit), 64'(e_commit));
        chk("err32",        64'(o32_err),    64'(e_err));
        chk("err64",        64'(o64_err),    64'(e_err));
        chk("gpr_w_addr32", 64'(o32_addr),   64'(e_addr));
        chk("gpr_w_addr64", 64'(o64_addr),   64'(e_addr));
        chk("gpr_w_data32", 64'(o32_data),   e_data[0]);
        chk("gpr_w_data64", o64_data,        e_data[1]);
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_waited = 0;
        e_en = 1'b0; e_commit = 1'b0; e_err = 1'b0;
        e_addr = '0; e_data[0] = '0; e_data[1] = '0;
    endtask

    task automatic model_cycle();
        e_en = 1'b0; e_commit = 1'b0; e_err = 1'b0;
        if (!rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (t_valid) begin
                if (t_sel == 2'd2) begin
                    m_busy = 1'b1; m_waited = 0;
                    m_rd = t_rd; m_size = t_size; m_uns = t_uns; m_addr = t_addr;
                end else begin
                    e_en = (t_sel != 2'd0) && (t_rd != 5'd0);
                    e_commit = 1'b1;
                    e_addr = t_rd;
                    for (int k = 0; k < 2; k++)
                        e_data[k] = ((t_sel == 2'd1) ? t_alu : t_pc + 64'd4) & wmask(k == 1 ? 64 : 32);
                end
            end
        end else begin
            m_waited++;
            if (t_rvalid) begin
                e_en = (m_rd != 5'd0);
                e_commit = 1'b1;
                e_addr = m_rd;
                for (int k = 0; k < 2; k++)
                    e_data[k] = m_ldext(k == 1 ? 64 : 32, t_rdata, m_size, m_uns, m_addr);
                m_busy = 1'b0;
            end else if (m_waited == TMO) begin
                e_err = 1'b1;
                e_commit = 1'b1;
                m_busy = 1'b0;
            end
        end
    endtask

    // Inputs are already driven; check ready, predict, clock, check outputs.
    task automatic step();
        check_ready();
        model_cycle();
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic drive(input logic [1:0] sel, input logic [4:0] rd, input logic [1:0] size,
                         input logic uns, input logic [2:0] addr, input logic [63:0] alu,
                         input logic [63:0] pc);
        t_valid = 1'b1; t_sel = sel; t_rd = rd; t_size = size; t_uns = uns;
        t_addr = addr; t_alu = alu; t_pc = pc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; t_valid = 1'b0; t_sel = '0; t_rd = '0; t_size = '0; t_uns = 1'b0;
        t_addr = '0; t_alu = '0; t_pc = '0; t_rvalid = 1'b0; t_rdata = '0;

        //          sel    rd     sz     uns   addr  alu                     pc                      rdata                  w  en    exp32                  exp64
        vt[0]  = '{2'd1, 5'd5,  2'd0, 1'b0, 3'd0, 64'h12345678,          64'h0,                  64'h0,                 0, 1'b1, 64'h12345678,          64'h12345678};
        vt[1]  = '{2'd1, 5'd6,  2'd0, 1'b0, 3'd0, 64'h1,                 64'h0,                  64'h0,                 0, 1'b1, 64'h1,                 64'h1};
        vt[2]  = '{2'd3, 5'd1,  2'd0, 1'b0, 3'd0, 64'h0,                 64'h80000000,           64'h0,                 0, 1'b1, 64'h80000004,          64'h80000004};
        vt[3]  = '{2'd3, 5'd0,  2'd0, 1'b0, 3'd0, 64'h0,                 64'h80000000,           64'h0,                 0, 1'b0, 64'h80000004,          64'h80000004};
        vt[4]  = '{2'd3, 5'd2,  2'd0, 1'b0, 3'd0, 64'h0,                 64'hFFFFFFFC,           64'h0,                 0, 1'b1, 64'h0,                 64'h1_0000_0000};
        vt[5]  = '{2'd1, 5'd31, 2'd0, 1'b0, 3'd0, 64'hFFFFFFFF_00000000, 64'h0,                  64'h0,                 0, 1'b1, 64'h0,                 64'hFFFFFFFF_00000000};
        vt[6]  = '{2'd0, 5'd9,  2'd0, 1'b0, 3'd0, 64'h55,                64'h100,                64'h0,                 0, 1'b0, 64'h104,               64'h104};
        vt[7]  = '{2'd2, 5'd7,  2'd0, 1'b0, 3'd3, 64'h0,                 64'h0,                  64'h80FF7F01,          4, 1'b1, 64'hFFFFFF80,          64'hFFFFFFFF_FFFFFF80};
        vt[8]  = '{2'd2, 5'd7,  2'd1, 1'b1, 3'd2, 64'h0,                 64'h0,                  64'h80FF7F01,          1, 1'b1, 64'h000080FF,          64'h000080FF};
        vt[9]  = '{2'd2, 5'd8,  2'd2, 1'b1, 3'd4, 64'h0,                 64'h0,                  64'hDEADBEEF_00000001, 2, 1'b1, 64'h1,                 64'h00000000_DEADBEEF};
        vt[10] = '{2'd2, 5'd8,  2'd2, 1'b0, 3'd4, 64'h0,                 64'h0,                  64'hDEADBEEF_00000001, 3, 1'b1, 64'h1,                 64'hFFFFFFFF_DEADBEEF};
        vt[11] = '{2'd2, 5'd8,  2'd3, 1'b0, 3'd4, 64'h0,                 64'h0,                  64'hDEADBEEF_00000001, 1, 1'b1, 64'h1,                 64'hDEADBEEF_00000001};
        vt[12] = '{2'd2, 5'd3,  2'd1, 1'b0, 3'd3, 64'h0,                 64'h0,                  64'h80FF7F01,          5, 1'b1, 64'hFFFF80FF,          64'hFFFFFFFF_FFFF80FF};
        vt[13] = '{2'd2, 5'd0,  2'd0, 1'b1, 3'd1, 64'h0,                 64'h0,                  64'h80FF7F01,          1, 1'b0, 64'h7F,                64'h7F};
        vt[14] = '{2'd2, 5'd10, 2'd0, 1'b0, 3'd7, 64'h0,                 64'h0,                  64'h7F000000_00000080, 2, 1'b1, 64'h0,                 64'h7F};

        // Reset state
        #12;
        check_ready();
        check_outs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: non-load rows issue back-to-back.
        for (int i = 0; i < 15; i++) begin
            drive(vt[i].sel, vt[i].rd, vt[i].size, vt[i].uns, vt[i].addr, vt[i].alu, vt[i].pc);
            t_rvalid = 1'b0;
            t_rdata  = vt[i].rdata;
            step();
            if (vt[i].sel == 2'd2) begin
                t_valid = 1'b0;
                for (int k = 1; k < vt[i].wait_n; k++) step();
                t_rvalid = 1'b1;
                step();
                t_rvalid = 1'b0;
            end
            chk($sformatf("vec%0d_en32", i),     64'(o32_en),     64'(vt[i].exp_en));
            chk($sformatf("vec%0d_en64", i),     64'(o64_en),     64'(vt[i].exp_en));
            chk($sformatf("vec%0d_commit32", i), 64'(o32_commit), 64'd1);
            chk($sformatf("vec%0d_data32", i),   64'(o32_data),   vt[i].exp32);
            chk($sformatf("vec%0d_data64", i),   o64_data,        vt[i].exp64);
        end
        t_valid = 1'b0;
        step();

        // Timeout: exactly TMO waiting cycles, then abort.
        drive(2'd2, 5'd12, 2'd2, 1'b0, 3'd0, 64'h0, 64'h0);
        step();
        t_valid = 1'b0;
        for (int k = 1; k < TMO; k++) step();
        chk("tmo_early_err32", 64'(o32_err),   64'd0);
        chk("tmo_still_busy",  64'(o32_ready), 64'd0);
        step();
        chk("tmo_err32",    64'(o32_err),    64'd1);
        chk("tmo_err64",    64'(o64_err),    64'd1);
        chk("tmo_commit32", 64'(o32_commit), 64'd1);
        chk("tmo_en32",     64'(o32_en),     64'd0);
        chk("tmo_idle",     64'(o32_ready),  64'd1);
        step();

        // Response in the expiry cycle wins.
        drive(2'd2, 5'd13, 2'd0, 1'b1, 3'd1, 64'h0, 64'h0);
        t_rdata = 64'h11223344_55667788;
        step();
        t_valid = 1'b0;
        for (int k = 1; k < TMO; k++) step();
        t_rvalid = 1'b1;
        step();
        t_rvalid = 1'b0;
        chk("late_rv_err32",  64'(o32_err),  64'd0);
        chk("late_rv_en64",   64'(o64_en),   64'd1);
        chk("late_rv_data32", 64'(o32_data), 64'h77);
        chk("late_rv_data64", o64_data,      64'h77);

        // Response while idle is ignored.
        t_rvalid = 1'b1;
        step();
        t_rvalid = 1'b0;

        // Asynchronous reset in the middle of a load.
        drive(2'd2, 5'd14, 2'd2, 1'b0, 3'd0, 64'h0, 64'h0);
        step();
        t_valid = 1'b0;
        step();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_ready();
        check_outs();
        chk("rst_data32_zero", 64'(o32_data), 64'd0);
        drive(2'd1, 5'd3, 2'd0, 1'b0, 3'd0, 64'hABCD, 64'h0);
        step();
        chk("rst_no_capture", 64'(o32_commit), 64'd0);
        #3;
        rst = 1'b1;
        t_valid  = 1'b0;
        t_rvalid = 1'b1;
        step();
        chk("rst_late_rv_commit", 64'(o64_commit), 64'd0);
        t_rvalid = 1'b0;
        drive(2'd1, 5'd4, 2'd0, 1'b0, 3'd0, 64'h5A5A, 64'h0);
        step();
        chk("rst_after_alu_en",   64'(o32_en),   64'd1);
        chk("rst_after_alu_data", 64'(o64_data), 64'h5A5A);
        t_valid = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            t_valid  = ($urandom_range(0, 3) != 0);
            t_sel    = 2'($urandom_range(0, 3));
            t_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            t_size   = 2'($urandom_range(0, 3));
            t_uns    = 1'($urandom_range(0, 1));
            t_addr   = 3'($urandom_range(0, 7));
            t_alu    = {$urandom, $urandom};
            t_pc     = {$urandom, $urandom};
            t_rdata  = {$urandom, $urandom};
            t_rvalid = ($urandom_range(0, 9) < 3);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
